// File: rtl/sound_sequencer_if.sv
// ---------------------------------------------------------------------------
// sound_sequencer_if
//
// Purpose
//   Bundles the game-side request signals and the DAC-side output signals of
//   the sound sequencer into one interface. The game logic (or a testbench)
//   uses the master modport; the sequencer itself uses the slave modport.
//
// Parameters
//   NUM_EV   number of event channels (channel 0 = highest priority)
//   DAC_W    width of the sawtooth sample sent to the DAC/PWM stage
//   PER_W    width of one channel's oscillator period field
//   DUR_W    width of one channel's tone duration field
//
// Signals
//   enable_i     master -> slave  0 = mute: nothing launches, tone aborts
//   event_i      master -> slave  level event inputs, rising edge = request
//   period_i     master -> slave  channel k period at [k*PER_W +: PER_W]
//   dur_i        master -> slave  channel k duration at [k*DUR_W +: DUR_W]
//   dacCount     slave -> master  sawtooth sample
//   playing_o    slave -> master  high while a tone is sounding
//   active_id_o  slave -> master  channel currently / last played
//   pending_o    slave -> master  queued request flags
// ---------------------------------------------------------------------------
interface sound_sequencer_if #(
   parameter int NUM_EV = 4,
   parameter int DAC_W  = 8,
   parameter int PER_W  = 12,
   parameter int DUR_W  = 16
);

   // A single channel still needs a one-bit id field.
   localparam int ID_W = (NUM_EV > 1) ? $clog2(NUM_EV) : 1;

   logic                      enable_i;
   logic [NUM_EV-1:0]         event_i;
   logic [NUM_EV*PER_W-1:0]   period_i;
   logic [NUM_EV*DUR_W-1:0]   dur_i;

   logic [DAC_W-1:0]          dacCount;
   logic                      playing_o;
   logic [ID_W-1:0]           active_id_o;
   logic [NUM_EV-1:0]         pending_o;

   modport master (
      output enable_i,
      output event_i,
      output period_i,
      output dur_i,
      input  dacCount,
      input  playing_o,
      input  active_id_o,
      input  pending_o
   );

   modport slave (
      input  enable_i,
      input  event_i,
      input  period_i,
      input  dur_i,
      output dacCount,
      output playing_o,
      output active_id_o,
      output pending_o
   );

endinterface : sound_sequencer_if

// File: rtl/sound_sequencer.sv
// ---------------------------------------------------------------------------
// sound_sequencer
//
// Purpose
//   Multi-channel tone sequencer placed between game logic and the DAC/PWM
//   output stage. Every rising edge on an event input queues a request for
//   that channel. Requests are served one at a time in fixed priority order
//   (channel 0 first). Each served request plays a sawtooth tone with the
//   channel's own period and duration, followed by a fixed silent gap.
//
// Parameters
//   NUM_EV   number of event channels (channel 0 = highest priority)
//   DAC_W    width of dacCount
//   PER_W    width of a channel period (clk cycles per DAC step)
//   DUR_W    width of a channel duration (clk cycles)
//   GAP_CYC  silent cycles after every completed tone (>= 1)
//
// Ports
//   clk    system clock
//   nRst   synchronous reset, active HIGH despite the name (1 = reset)
//   bus    sound_sequencer_if.slave: enable_i, event_i, period_i, dur_i in;
//          dacCount, playing_o, active_id_o, pending_o out
//
// Build option
//   SOUND_PREEMPT_EN  when defined, a pending request from a higher-priority
//                     channel cuts the current tone short and starts at once
//                     (no gap). When undefined, every tone runs to its end
//                     and is followed by the gap.
// ---------------------------------------------------------------------------
module sound_sequencer #(
   parameter int NUM_EV  = 4,
   parameter int DAC_W   = 8,
   parameter int PER_W   = 12,
   parameter int DUR_W   = 16,
   parameter int GAP_CYC = 64
) (
   input  logic             clk,
   input  logic             nRst,
   sound_sequencer_if.slave bus
);

   localparam int ID_W  = (NUM_EV > 1)  ? $clog2(NUM_EV)  : 1;
   localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_PLAY,
      S_GAP
   } state_t;

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   state_t             state_q,     state_d;
   logic [NUM_EV-1:0]  event_q;
   logic [NUM_EV-1:0]  pending_q,   pending_d;
   logic [PER_W-1:0]   period_q,    period_d;
   logic [DUR_W-1:0]   dur_cnt_q,   dur_cnt_d;
   logic [PER_W-1:0]   osc_cnt_q,   osc_cnt_d;
   logic [DAC_W-1:0]   dac_q,       dac_d;
   logic [ID_W-1:0]    active_id_q, active_id_d;
   logic [GAP_W-1:0]   gap_cnt_q,   gap_cnt_d;

   // ------------------------------------------------------------------------
   // Request selection
   // ------------------------------------------------------------------------
   logic [NUM_EV-1:0]  rise;
   logic               any_pending;
   logic [ID_W-1:0]    sel_idx;
   logic [PER_W-1:0]   sel_period;
   logic [DUR_W-1:0]   sel_dur;
   logic               sel_valid;
   logic               preempt_req;
   logic               take_req;
   logic [NUM_EV-1:0]  clr_mask;

   assign rise        = bus.event_i & ~event_q;
   assign any_pending = |pending_q;

   // Lowest set pending index wins. Scanning downwards lets the last hit
   // (the lowest index) overwrite any higher one.
   always_comb begin
      sel_idx = '0;
      for (int k = NUM_EV - 1; k >= 0; k--) begin
         if (pending_q[k]) begin
            sel_idx = ID_W'(k);
         end
      end
   end

   // Period and duration are only looked at here, i.e. at launch time; the
   // running tone works from its own latched copies.
   assign sel_period = bus.period_i[int'(sel_idx)*PER_W +: PER_W];
   assign sel_dur    = bus.dur_i[int'(sel_idx)*DUR_W +: DUR_W];
   assign sel_valid  = (sel_period != '0) && (sel_dur != '0);

`ifdef SOUND_PREEMPT_EN
   // Only a strictly higher-priority channel may cut in; an equal or lower
   // one waits for the tone and gap to finish.
   assign preempt_req = any_pending && (sel_idx < active_id_q);
`else
   assign preempt_req = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // Next-state and datapath logic
   // ------------------------------------------------------------------------
   always_comb begin
      // NOTE: every variable gets a default before the case statement, so no
      // path through this block can leave one unassigned and infer a latch.
      state_d     = state_q;
      period_d    = period_q;
      dur_cnt_d   = dur_cnt_q;
      osc_cnt_d   = osc_cnt_q;
      dac_d       = dac_q;
      active_id_d = active_id_q;
      gap_cnt_d   = gap_cnt_q;
      take_req    = 1'b0;
      clr_mask    = '0;

      unique case (state_q)
         S_IDLE: begin
            dac_d = '0;
            if (bus.enable_i && any_pending) begin
               take_req = 1'b1;
            end
         end

         S_PLAY: begin
            if (!bus.enable_i) begin
               // Muting drops the tone; queued requests are left untouched.
               state_d = S_IDLE;
               dac_d   = '0;
            end else if (preempt_req) begin
               take_req = 1'b1;
            end else begin
               // The step to the next DAC level happens on the wrap cycle,
               // so level n is held for exactly 'period' cycles.
               if (osc_cnt_q == period_q - PER_W'(1)) begin
                  osc_cnt_d = '0;
                  dac_d     = dac_q + DAC_W'(1);
               end else begin
                  osc_cnt_d = osc_cnt_q + PER_W'(1);
               end
               dur_cnt_d = dur_cnt_q - DUR_W'(1);
               // dur_cnt was loaded with dur, so reaching 1 here means this
               // is the last of exactly dur cycles in PLAY.
               if (dur_cnt_q == DUR_W'(1)) begin
                  state_d   = S_GAP;
                  dac_d     = '0;
                  gap_cnt_d = '0;
               end
            end
         end

         S_GAP: begin
            dac_d = '0;
            if (!bus.enable_i || (gap_cnt_q == GAP_W'(GAP_CYC - 1))) begin
               state_d = S_IDLE;
            end else begin
               gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
         end

         default: begin
            state_d = S_IDLE;
            dac_d   = '0;
         end
      endcase

      // Launching is identical from IDLE and from a preempted PLAY. A
      // request with a zero period or duration is consumed but never played.
      if (take_req) begin
         clr_mask[sel_idx] = 1'b1;
         dac_d             = '0;
         if (sel_valid) begin
            state_d     = S_PLAY;
            period_d    = sel_period;
            dur_cnt_d   = sel_dur;
            osc_cnt_d   = '0;
            active_id_d = sel_idx;
         end else begin
            state_d = S_IDLE;
         end
      end
   end

   // A new rise is OR-ed in after the clear, so a request arriving in the
   // same cycle its channel is launched is kept for a later replay.
   assign pending_d = (pending_q & ~clr_mask) | rise;

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (nRst) begin
         state_q     <= S_IDLE;
         event_q     <= '0;
         pending_q   <= '0;
         period_q    <= '0;
         dur_cnt_q   <= '0;
         osc_cnt_q   <= '0;
         dac_q       <= '0;
         active_id_q <= '0;
         gap_cnt_q   <= '0;
      end else begin
         state_q     <= state_d;
         event_q     <= bus.event_i;
         pending_q   <= pending_d;
         period_q    <= period_d;
         dur_cnt_q   <= dur_cnt_d;
         osc_cnt_q   <= osc_cnt_d;
         dac_q       <= dac_d;
         active_id_q <= active_id_d;
         gap_cnt_q   <= gap_cnt_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign bus.dacCount    = dac_q;
   assign bus.playing_o   = (state_q == S_PLAY);
   assign bus.active_id_o = active_id_q;
   assign bus.pending_o   = pending_q;

endmodule : sound_sequencer

// File: tb/tb_sound_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sound_sequencer
//
// Purpose
//   Self-checking bench for sound_sequencer. Directed scenarios (reset,
//   single tone, priority, discard, DAC wrap, preemption, mute, re-trigger)
//   are followed by a randomized phase. A reference model describes the
//   output in terms of "time since the tone started": during a tone the DAC
//   value is floor(t / period) mod 2^DAC_W, otherwise 0.
//   Build with +define+SOUND_PREEMPT_EN to exercise the preemption variant.
// ---------------------------------------------------------------------------
module tb_sound_sequencer;

   localparam int NUM_EV  = 4;
   localparam int DAC_W   = 8;
   localparam int PER_W   = 12;
   localparam int DUR_W   = 16;
   localparam int GAP_CYC = 64;

`ifdef SOUND_PREEMPT_EN
   localparam bit PREEMPT = 1'b1;
`else
   localparam bit PREEMPT = 1'b0;
`endif

   logic clk = 1'b0;
   logic nRst;

   always #5 clk = ~clk;

   sound_sequencer_if #(
      .NUM_EV(NUM_EV), .DAC_W(DAC_W), .PER_W(PER_W), .DUR_W(DUR_W)
   ) bus ();

   sound_sequencer #(
      .NUM_EV(NUM_EV), .DAC_W(DAC_W), .PER_W(PER_W), .DUR_W(DUR_W),
      .GAP_CYC(GAP_CYC)
   ) dut (
      .clk  (clk),
      .nRst (nRst),
      .bus  (bus)
   );

   // ------------------------------------------------------------------------
   // Bookkeeping
   // ------------------------------------------------------------------------
   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
      end
   endtask

   // ------------------------------------------------------------------------
   // Channel configuration
   // ------------------------------------------------------------------------
   int cfg_per [NUM_EV];
   int cfg_dur [NUM_EV];

   task automatic apply_cfg();
      for (int k = 0; k < NUM_EV; k++) begin
         bus.period_i[k*PER_W +: PER_W] = PER_W'(cfg_per[k]);
         bus.dur_i[k*DUR_W +: DUR_W]    = DUR_W'(cfg_dur[k]);
      end
   endtask

   // ------------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------------
   typedef enum int {M_IDLE, M_PLAY, M_GAP} mmode_t;

   mmode_t            m_mode = M_IDLE;
   int                m_t    = 0;    // cycles since the current phase began
   int                m_per  = 1;
   int                m_dur  = 1;
   int                m_id   = 0;
   logic [NUM_EV-1:0] m_pend = '0;
   logic [NUM_EV-1:0] m_evq  = '0;

   // Advance the model by one clock edge using the inputs as the DUT sees them.
   task automatic model_update();
      logic [NUM_EV-1:0] rise;
      int                low;
      bit                take;
      if (nRst) begin
         m_mode = M_IDLE;
         m_t    = 0;
         m_pend = '0;
         m_evq  = '0;
         m_id   = 0;
         return;
      end
      rise  = bus.event_i & ~m_evq;
      m_evq = bus.event_i;
      low   = -1;
      for (int k = NUM_EV - 1; k >= 0; k--) begin
         if (m_pend[k]) low = k;
      end
      take = 1'b0;
      case (m_mode)
         M_IDLE: if (bus.enable_i && low >= 0) take = 1'b1;
         M_PLAY: begin
            if (!bus.enable_i)                          m_mode = M_IDLE;
            else if (PREEMPT && low >= 0 && low < m_id) take = 1'b1;
            else if (m_t == m_dur - 1) begin
               m_mode = M_GAP;
               m_t    = 0;
            end else m_t++;
         end
         default: begin
            if (!bus.enable_i || m_t == GAP_CYC - 1) m_mode = M_IDLE;
            else m_t++;
         end
      endcase
      if (take) begin
         m_pend[low] = 1'b0;
         if (cfg_per[low] != 0 && cfg_dur[low] != 0) begin
            m_mode = M_PLAY;
            m_t    = 0;
            m_per  = cfg_per[low];
            m_dur  = cfg_dur[low];
            m_id   = low;
         end else begin
            m_mode = M_IDLE;
         end
      end
      m_pend = m_pend | rise;
   endtask

   function automatic logic [31:0] exp_dac();
      if (m_mode == M_PLAY) return 32'((m_t / m_per) % (1 << DAC_W));
      return 32'd0;
   endfunction

   // One clock: update the model, let the edge happen, compare 1 ns later.
   task automatic step();
      model_update();
      @(posedge clk);
      #1;
      check("dac",       32'(bus.dacCount),    exp_dac());
      check("playing",   32'(bus.playing_o),   32'(m_mode == M_PLAY));
      check("pending",   32'(bus.pending_o),   32'(m_pend));
      check("active_id", 32'(bus.active_id_o), 32'(m_id));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   int play_cnt;

   initial begin
      nRst         = 1'b1;
      bus.enable_i = 1'b1;
      bus.event_i  = '0;
      cfg_per = '{2, 3, 5, 0};
      cfg_dur = '{10, 12, 40, 20};
      apply_cfg();

      // Reset state
      run(2);
      check("rst_dac",     32'(bus.dacCount),    32'd0);
      check("rst_playing", 32'(bus.playing_o),   32'd0);
      check("rst_pending", 32'(bus.pending_o),   32'd0);
      nRst = 1'b0;

      // Single event on channel 1: period 3, duration 12
      bus.event_i[1] = 1'b1;
      step();
      check("single_pend",    32'(bus.pending_o), 32'b0010);
      check("single_notyet",  32'(bus.playing_o), 32'd0);
      bus.event_i[1] = 1'b0;
      step();
      check("single_play",    32'(bus.playing_o),   32'd1);
      check("single_id",      32'(bus.active_id_o), 32'd1);
      play_cnt = 1;
      for (int i = 1; i < 90; i++) begin
         step();
         if (i == 9) check("single_dac9", 32'(bus.dacCount), 32'd3);
         if (bus.playing_o) play_cnt++;
      end
      check("single_len", 32'(play_cnt), 32'd12);

      // Priority: channels 0 and 2 in the same cycle
      bus.event_i = 4'b0101;
      step();
      check("prio_pend", 32'(bus.pending_o), 32'b0101);
      bus.event_i = '0;
      step();
      check("prio_first_id", 32'(bus.active_id_o), 32'd0);
      check("prio_wait",     32'(bus.pending_o),   32'b0100);
      run(75);
      check("prio_second_id",   32'(bus.active_id_o), 32'd2);
      check("prio_second_play", 32'(bus.playing_o),   32'd1);
      run(111);

      // Discard: channel 3 has a zero period
      bus.event_i[3] = 1'b1;
      step();
      check("discard_pend", 32'(bus.pending_o), 32'b1000);
      bus.event_i[3] = 1'b0;
      step();
      check("discard_clr",  32'(bus.pending_o), 32'd0);
      check("discard_play", 32'(bus.playing_o), 32'd0);
      check("discard_dac",  32'(bus.dacCount),  32'd0);

      // DAC wrap: period 1, duration 300
      cfg_per[1] = 1;
      cfg_dur[1] = 300;
      apply_cfg();
      bus.event_i[1] = 1'b1;
      step();
      bus.event_i[1] = 1'b0;
      step();
      run(255);
      check("wrap_255", 32'(bus.dacCount), 32'd255);
      step();
      check("wrap_0",    32'(bus.dacCount),  32'd0);
      check("wrap_play", 32'(bus.playing_o), 32'd1);
      run(120);
      cfg_per[1] = 3;
      cfg_dur[1] = 12;
      apply_cfg();

      // Higher-priority request while channel 2 plays
      bus.event_i[2] = 1'b1;
      step();
      bus.event_i[2] = 1'b0;
      step();
      run(5);
      bus.event_i[0] = 1'b1;
      step();
      bus.event_i[0] = 1'b0;
      step();
      check("preempt_id",   32'(bus.active_id_o), PREEMPT ? 32'd0 : 32'd2);
      check("preempt_play", 32'(bus.playing_o),   32'd1);
      run(97);
      check("preempt_late_id",   32'(bus.active_id_o), PREEMPT ? 32'd0 : 32'd2);
      check("preempt_late_play", 32'(bus.playing_o),   32'd0);
      step();
      check("preempt_ch0_id",   32'(bus.active_id_o), 32'd0);
      check("preempt_ch0_play", 32'(bus.playing_o),   PREEMPT ? 32'd0 : 32'd1);
      run(80);

      // Mute mid-tone; requests made while muted are held
      bus.event_i[1] = 1'b1;
      step();
      bus.event_i[1] = 1'b0;
      step();
      run(4);
      bus.enable_i = 1'b0;
      step();
      check("mute_stop", 32'(bus.playing_o), 32'd0);
      check("mute_dac",  32'(bus.dacCount),  32'd0);
      bus.event_i[0] = 1'b1;
      step();
      bus.event_i[0] = 1'b0;
      run(2);
      check("mute_hold", 32'(bus.pending_o), 32'b0001);
      check("mute_idle", 32'(bus.playing_o), 32'd0);
      bus.enable_i = 1'b1;
      step();
      check("unmute_play", 32'(bus.playing_o),   32'd1);
      check("unmute_id",   32'(bus.active_id_o), 32'd0);
      run(80);

      // Re-trigger the playing channel
      bus.event_i[1] = 1'b1;
      step();
      bus.event_i[1] = 1'b0;
      step();
      run(3);
      bus.event_i[1] = 1'b1;
      step();
      check("retrig_pend", 32'(bus.pending_o), 32'b0010);
      bus.event_i[1] = 1'b0;
      run(72);
      check("retrig_gap",  32'(bus.playing_o), 32'd0);
      step();
      check("retrig_play", 32'(bus.playing_o),   32'd1);
      check("retrig_id",   32'(bus.active_id_o), 32'd1);
      run(80);

      // Reset in the middle of a tone, with another request pending
      bus.event_i[2] = 1'b1;
      step();
      bus.event_i[2] = 1'b0;
      step();
      bus.event_i[3] = 1'b1;
      run(5);
      bus.event_i = '0;
      nRst = 1'b1;
      step();
      check("midrst_dac",     32'(bus.dacCount),    32'd0);
      check("midrst_playing", 32'(bus.playing_o),   32'd0);
      check("midrst_pending", 32'(bus.pending_o),   32'd0);
      check("midrst_id",      32'(bus.active_id_o), 32'd0);
      nRst = 1'b0;
      step();

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         for (int k = 0; k < NUM_EV; k++) begin
            if ($urandom_range(0, 19) == 0) bus.event_i[k] = ~bus.event_i[k];
         end
         bus.enable_i = ($urandom_range(0, 49) != 0);
         if ($urandom_range(0, 59) == 0) begin
            int k;
            k = int'($urandom_range(0, NUM_EV - 1));
            cfg_per[k] = int'($urandom_range(0, 6));
            cfg_dur[k] = int'($urandom_range(0, 40));
            apply_cfg();
         end
         nRst = ($urandom_range(0, 999) == 0);
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_sound_sequencer
